// File: rtl/arbitro_rolhas.sv
// arbitro_rolhas: arbiter and sequencer for the shared cork-stock counter.
// Serves the capping station (dec) and the refill feeder (inc) over a
// req/ack/nack handshake and keeps the count saturating in 0..MAX_ROLHAS.
//
// Ports:
//   clk, reset             line clock, asynchronous active-high reset
//   dec_req/dec_ack/nack   capping station: take one cork
//   inc_req/inc_ack/nack   feeder: deliver one cork
//   count                  current stock
//   rolha_ok, low_stock    count != 0, count <= LOW_TH
//   full                   count == MAX_ROLHAS
//   erro                   sticky release-timeout flag
//
// Optional feature: define ARBITRO_ROLHAS_TIMEOUT_EN to build the WAIT_REL
// watchdog (TIMEOUT cycles). Without it, erro is tied 0.
module arbitro_rolhas #(
    parameter int unsigned WIDTH      = 5,
    parameter int unsigned MAX_ROLHAS = 31,
    parameter int unsigned LOW_TH     = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_req,
    output logic             dec_ack,
    output logic             dec_nack,
    input  logic             inc_req,
    output logic             inc_ack,
    output logic             inc_nack,
    output logic [WIDTH-1:0] count,
    output logic             rolha_ok,
    output logic             low_stock,
    output logic             full,
    output logic             erro
);

    typedef enum logic [2:0] {
        StIdle, StAckDec, StAckInc, StNackDec, StNackInc, StWaitRel
    } state_e;

    typedef enum logic {GrantDec, GrantInc} grant_e;

    state_e           state_q, state_d;
    grant_e           last_grant_q, last_grant_d;
    logic             served_dec_q, served_dec_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             dec_v, inc_v, pick_dec, served_req;

    assign served_req = served_dec_q ? dec_req : inc_req;

`ifdef ARBITRO_ROLHAS_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] tmo_q, tmo_d;
    logic          erro_q, erro_d;
    // Set on timeout; a blocked requester is ignored until its req is seen low.
    logic          blk_dec_q, blk_dec_d, blk_inc_q, blk_inc_d;

    assign dec_v = dec_req & ~blk_dec_q;
    assign inc_v = inc_req & ~blk_inc_q;
    assign erro  = erro_q;
`else
    assign dec_v = dec_req;
    assign inc_v = inc_req;
    assign erro  = 1'b0;
`endif

    // On a tie the requester not served last wins.
    assign pick_dec = (dec_v && inc_v) ? (last_grant_q == GrantInc) : dec_v;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= GrantInc;
            served_dec_q <= 1'b0;
            count_q      <= '0;
`ifdef ARBITRO_ROLHAS_TIMEOUT_EN
            tmo_q        <= '0;
            erro_q       <= 1'b0;
            blk_dec_q    <= 1'b0;
            blk_inc_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            served_dec_q <= served_dec_d;
            count_q      <= count_d;
`ifdef ARBITRO_ROLHAS_TIMEOUT_EN
            tmo_q        <= tmo_d;
            erro_q       <= erro_d;
            blk_dec_q    <= blk_dec_d;
            blk_inc_q    <= blk_inc_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        served_dec_d = served_dec_q;
        count_d      = count_q;
`ifdef ARBITRO_ROLHAS_TIMEOUT_EN
        tmo_d        = '0;
        erro_d       = erro_q;
        blk_dec_d    = blk_dec_q & dec_req;
        blk_inc_d    = blk_inc_q & inc_req;
`endif
        unique case (state_q)
            StIdle: begin
                if (dec_v || inc_v) begin
                    served_dec_d = pick_dec;
                    if (pick_dec) begin
                        last_grant_d = GrantDec;
                        if (count_q != '0) begin
                            state_d = StAckDec;
                            count_d = count_q - 1'b1;
                        end else begin
                            state_d = StNackDec;
                        end
                    end else begin
                        last_grant_d = GrantInc;
                        if (count_q < WIDTH'(MAX_ROLHAS)) begin
                            state_d = StAckInc;
                            count_d = count_q + 1'b1;
                        end else begin
                            state_d = StNackInc;
                        end
                    end
                end
            end
            StAckDec, StAckInc, StNackDec, StNackInc: state_d = StWaitRel;
            StWaitRel: begin
                if (!served_req) begin
                    state_d = StIdle;
`ifdef ARBITRO_ROLHAS_TIMEOUT_EN
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = StIdle;
                    erro_d  = 1'b1;
                    if (served_dec_q) blk_dec_d = 1'b1;
                    else              blk_inc_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs
    always_comb begin
        dec_ack  = 1'b0;
        dec_nack = 1'b0;
        inc_ack  = 1'b0;
        inc_nack = 1'b0;
        unique case (state_q)
            StAckDec:  dec_ack  = 1'b1;
            StNackDec: dec_nack = 1'b1;
            StAckInc:  inc_ack  = 1'b1;
            StNackInc: inc_nack = 1'b1;
            default: ;
        endcase
    end

    assign count     = count_q;
    assign rolha_ok  = (count_q != '0);
    assign low_stock = (count_q <= WIDTH'(LOW_TH));
    assign full      = (count_q == WIDTH'(MAX_ROLHAS));

endmodule

// File: tb/tb_arbitro_rolhas.sv
// Directed bench for arbitro_rolhas (default parameters).
module tb_arbitro_rolhas;

`ifdef ARBITRO_ROLHAS_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dec_req = 1'b0, inc_req = 1'b0;
    logic       dec_ack, dec_nack, inc_ack, inc_nack;
    logic [4:0] count;
    logic       rolha_ok, low_stock, full, erro;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    arbitro_rolhas dut (
        .clk       (clk),
        .reset     (reset),
        .dec_req   (dec_req),
        .dec_ack   (dec_ack),
        .dec_nack  (dec_nack),
        .inc_req   (inc_req),
        .inc_ack   (inc_ack),
        .inc_nack  (inc_nack),
        .count     (count),
        .rolha_ok  (rolha_ok),
        .low_stock (low_stock),
        .full      (full),
        .erro      (erro)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Responses packed as {dec_ack, dec_nack, inc_ack, inc_nack}.
    function automatic logic [3:0] resp();
        return {dec_ack, dec_nack, inc_ack, inc_nack};
    endfunction

    // One lone transaction from IDLE at posedge+1; returns at posedge+1 in IDLE.
    task automatic txn(input bit is_dec, input logic [3:0] exp_resp, input logic [4:0] exp_cnt);
        if (is_dec) dec_req = 1'b1;
        else        inc_req = 1'b1;
        @(posedge clk); #1;
        check(is_dec ? "dec_resp" : "inc_resp", resp(), exp_resp);
        check("txn_count", count, exp_cnt);
        dec_req = 1'b0;
        inc_req = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("resp_idle", resp(), 4'b0000);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        // Reset state, during reset and after idling
        @(posedge clk); #1;
        check("rst_count", count, 0);
        check("rst_flags", {rolha_ok, low_stock, full, erro}, 4'b0100);
        check("rst_resp", resp(), 4'b0000);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_count", count, 0);
        check("idle_flags", {rolha_ok, low_stock, full, erro}, 4'b0100);
        check("idle_resp", resp(), 4'b0000);

        // Empty stock: dec refused
        txn(1'b1, 4'b0100, 5'd0);

        // Five deliveries, low_stock drops at 5, one dec brings it back
        for (int i = 1; i <= 5; i++) begin
            txn(1'b0, 4'b0010, 5'(i));
            check("low_stock_up", low_stock, (i <= 4));
            check("rolha_ok_up", rolha_ok, 1'b1);
        end
        txn(1'b1, 4'b1000, 5'd4);
        check("low_stock_back", low_stock, 1'b1);

        // Up to 10, then tie: dec wins first (last_grant starts at INC)
        for (int i = 5; i <= 10; i++) txn(1'b0, 4'b0010, 5'(i));
        dec_req = 1'b1;
        inc_req = 1'b1;
        @(posedge clk); #1;
        check("tie1_first", resp(), 4'b1000);
        check("tie1_count", count, 9);
        dec_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("tie1_wait", resp(), 4'b0000);
        @(posedge clk); #1;
        check("tie1_second", resp(), 4'b0010);
        check("tie1_count2", count, 10);
        inc_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Last grant made DEC, so the next tie goes to INC
        txn(1'b1, 4'b1000, 5'd9);
        dec_req = 1'b1;
        inc_req = 1'b1;
        @(posedge clk); #1;
        check("tie2_first", resp(), 4'b0010);
        check("tie2_count", count, 10);
        inc_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("tie2_second", resp(), 4'b1000);
        check("tie2_count2", count, 9);
        dec_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Fill to saturation, then one more delivery is refused
        do_reset();
        for (int i = 1; i <= 31; i++) begin
            txn(1'b0, 4'b0010, 5'(i));
            check("full_flag", full, (i == 31));
        end
        txn(1'b0, 4'b0001, 5'd31);
        check("full_hold", full, 1'b1);

        // Reset during ACK_DEC from count 7
        do_reset();
        for (int i = 1; i <= 7; i++) txn(1'b0, 4'b0010, 5'(i));
        dec_req = 1'b1;
        @(posedge clk); #1;
        check("mid_ack", resp(), 4'b1000);
        check("mid_count", count, 6);
        reset = 1'b1;
        #1;
        check("abort_resp", resp(), 4'b0000);
        check("abort_count", count, 0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_nack", resp(), 4'b0100);
        check("post_rst_count", count, 0);
        dec_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Stuck dec_req after its ack, with inc pending
        txn(1'b0, 4'b0010, 5'd1);
        dec_req = 1'b1;
        @(posedge clk); #1;
        check("stuck_ack", resp(), 4'b1000);
        check("stuck_count", count, 0);
        inc_req = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("erro_before", erro, 1'b0);
        @(posedge clk); #1;
        check("erro_after", erro, TMO);
        @(posedge clk); #1;
        check("inc_after_stuck", resp(), TMO ? 4'b0010 : 4'b0000);
        if (!TMO) begin
            dec_req = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check("inc_after_release", resp(), 4'b0010);
        end
        check("inc_count", count, 1);
        dec_req = 1'b0;
        inc_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("erro_sticky", erro, TMO);
        check("final_resp", resp(), 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
